branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC/target width in bits.
REQ-002 SHALL have parameter IDX_W, default 4, meaning log2 of entry count (16 entries).
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port PcIn, input, PC_W, the fetch-stage PC to look up.
REQ-006 SHALL have port Stall, input, 1, which holds the lookup pipeline register.
REQ-007 SHALL have port Flush, input, 1, which clears the lookup pipeline register (the FlushPipePC of the branch unit).
REQ-008 SHALL have port WriteEnable, input, 1, the entry update strobe from the branch unit.
REQ-009 SHALL have port WrPc, input, PC_W, the PC of the resolved branch/jump being written.
REQ-010 SHALL have port WrTarget, input, PC_W, the resolved target.
REQ-011 SHALL have port WrCtrl, input, 2, the new 2-bit predictor state (the branch unit's CtrlOut).
REQ-012 SHALL have port HitF, output, 1, the combinational fetch-stage hit.
REQ-013 SHALL have port PredTakenF, output, 1, combinational: HitF AND ctrl[1].
REQ-014 SHALL have port PredTargetF, output, PC_W, the combinational predicted target (0 on miss).
REQ-015 SHALL have port PcMatchValid, output, 1, the registered hit, aligned with the instruction reaching the branch unit.
REQ-016 SHALL have port CtrlIn, output, 2, the registered predictor state for that instruction (00 on miss).

Function
REQ-017 SHALL be direct-mapped: index = PC[IDX_W+1:2], tag = PC[PC_W-1:IDX_W+2]; each entry holds valid, tag, target and ctrl.
REQ-018 SHALL assert HitF iff the indexed entry is valid and its tag equals the PcIn tag.
REQ-019 SHALL, when WriteEnable=1, write valid=1, tag, WrTarget and WrCtrl at the WrPc index on the rising edge, unconditionally overwriting any alias.
REQ-020 SHALL bypass write data to the fetch outputs in the same cycle when WriteEnable=1 and the WrPc index equals the PcIn index, so that the lookup reflects post-write contents.
REQ-021 SHALL register {HitF, ctrl} into {PcMatchValid, CtrlIn} each cycle: latency 1 cycle.
REQ-022 SHALL give Flush priority over Stall: Flush=1 loads PcMatchValid=0 and CtrlIn=00; Stall=1 with Flush=0 holds the register.
REQ-023 SHALL leave the storage array unaffected by Stall and Flush; WriteEnable is honoured regardless of either.
REQ-024 SHALL return PredTargetF=0 and ctrl=00 whenever HitF=0.
REQ-025 SHALL have no invalidation path other than reset.

Reset
REQ-026 SHALL, on RST, immediately clear all valid bits, PcMatchValid=0 and CtrlIn=00; HitF, PredTakenF and PredTargetF then read 0 combinationally.
REQ-027 SHALL leave tag, target and ctrl arrays unreset.
REQ-028 SHALL ignore a WriteEnable coincident with RST; reset mid-stall SHALL discard the held value.

Structure
REQ-029 SHALL take the predictor encoding constants (00/01 not-taken, 10/11 taken) and default widths from the shared hazard-unit package.
REQ-030 SHALL have one natural sub-module, btb_storage: the valid/tag/target/ctrl array with one async read port and one sync write port.

Verification
REQ-031 Bench SHALL check reset with PcIn=0x40 -> HitF=0; next cycle PcMatchValid=0 and CtrlIn=00.
REQ-032 Bench SHALL check a write of WrPc=0x40, WrTarget=0x100, WrCtrl=10, then PcIn=0x40 -> HitF=1, PredTakenF=1, PredTargetF=0x100; next cycle CtrlIn=10.
REQ-033 Bench SHALL check alias handling: after entry 0x40, a lookup of PcIn=0x80 (same index, tag differs) -> HitF=0; a write of 0x80 then makes PcIn=0x40 miss.
REQ-034 Bench SHALL check the bypass: WriteEnable with WrPc=PcIn=0x44 and WrCtrl=01 in the same cycle -> HitF=1 and PredTakenF=0 in that cycle.
REQ-035 Bench SHALL check Stall=1 for 2 cycles -> CtrlIn holds; Stall=1 together with Flush=1 -> PcMatchValid=0 next cycle.
REQ-036 Bench SHALL check RST asserted mid-operation after 3 writes -> all subsequent lookups miss until rewritten.

Source files
------------

// File: rtl/branch_target_buffer_pkg.sv
// Shared hazard-unit definitions: default BTB geometry and the 2-bit
// branch predictor encoding consumed by the branch target buffer.
package branch_target_buffer_pkg;

   localparam int PC_W_DEF  = 32;
   localparam int IDX_W_DEF = 4;

   typedef enum logic [1:0] {
      CTRL_STRONG_NT = 2'b00,
      CTRL_WEAK_NT   = 2'b01,
      CTRL_WEAK_T    = 2'b10,
      CTRL_STRONG_T  = 2'b11
   } predCtrl_t;

   // The upper predictor bit alone decides the taken direction.
   function automatic logic isTaken(input logic [1:0] ctrl);
      return ctrl[1];
   endfunction

endpackage

// File: rtl/branch_target_buffer_storage.sv
// Direct-mapped BTB entry array: async read port for fetch, sync write port
// from the branch unit. Only the valid bits are reset.
module btb_storage
   import branch_target_buffer_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int TAG_W = PC_W - IDX_W - 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [IDX_W-1:0] RdIdx,
   output logic             RdValid,
   output logic [TAG_W-1:0] RdTag,
   output logic [PC_W-1:0]  RdTarget,
   output logic [1:0]       RdCtrl,
   input  logic             WrEn,
   input  logic [IDX_W-1:0] WrIdx,
   input  logic [TAG_W-1:0] WrTag,
   input  logic [PC_W-1:0]  WrTarget,
   input  logic [1:0]       WrCtrl
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [ENTRIES-1:0] validBits;
   logic [TAG_W-1:0]   tagArr    [ENTRIES];
   logic [PC_W-1:0]    targetArr [ENTRIES];
   logic [1:0]         ctrlArr   [ENTRIES];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         validBits <= '0;
      end else if (WrEn) begin
         validBits[WrIdx] <= 1'b1;
      end
   end

   // Payload is never reset; a cleared valid bit masks stale contents.
   always_ff @(posedge CLK) begin
      if (WrEn) begin
         tagArr[WrIdx]    <= WrTag;
         targetArr[WrIdx] <= WrTarget;
         ctrlArr[WrIdx]   <= WrCtrl;
      end
   end

   assign RdValid  = validBits[RdIdx];
   assign RdTag    = tagArr[RdIdx];
   assign RdTarget = targetArr[RdIdx];
   assign RdCtrl   = ctrlArr[RdIdx];

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage branch target buffer: combinational lookup with write bypass,
// plus a one-stage register carrying hit/ctrl to the branch unit.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [PC_W-1:0] PcIn,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            WriteEnable,
   input  logic [PC_W-1:0] WrPc,
   input  logic [PC_W-1:0] WrTarget,
   input  logic [1:0]      WrCtrl,
   output logic            HitF,
   output logic            PredTakenF,
   output logic [PC_W-1:0] PredTargetF,
   output logic            PcMatchValid,
   output logic [1:0]      CtrlIn
);

   localparam int TAG_W = PC_W - IDX_W - 2;

   logic [IDX_W-1:0] fetchIdx;
   logic [TAG_W-1:0] fetchTag;
   logic [IDX_W-1:0] wrIdx;
   logic [TAG_W-1:0] wrTag;
   logic             unusedPcLsbs;

   logic             rdValid;
   logic [TAG_W-1:0] rdTag;
   logic [PC_W-1:0]  rdTarget;
   logic [1:0]       rdCtrl;

   logic             bypass;
   logic             entValid;
   logic [TAG_W-1:0] entTag;
   logic [PC_W-1:0]  entTarget;
   logic [1:0]       entCtrl;
   logic             hitF;
   logic [1:0]       ctrlF;

   logic             matchVld_p1;
   logic [1:0]       ctrl_p1;

   assign fetchIdx     = PcIn[IDX_W+1:2];
   assign fetchTag     = PcIn[PC_W-1:IDX_W+2];
   assign wrIdx        = WrPc[IDX_W+1:2];
   assign wrTag        = WrPc[PC_W-1:IDX_W+2];
   assign unusedPcLsbs = ^{PcIn[1:0], WrPc[1:0]};

   btb_storage #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) uStorage (
      .CLK      (CLK),
      .RST      (RST),
      .RdIdx    (fetchIdx),
      .RdValid  (rdValid),
      .RdTag    (rdTag),
      .RdTarget (rdTarget),
      .RdCtrl   (rdCtrl),
      .WrEn     (WriteEnable),
      .WrIdx    (wrIdx),
      .WrTag    (wrTag),
      .WrTarget (WrTarget),
      .WrCtrl   (WrCtrl)
   );

   // Same-index write in flight: present the entry as it will be after the edge.
   assign bypass    = WriteEnable && (wrIdx == fetchIdx);
   assign entValid  = bypass ? 1'b1     : rdValid;
   assign entTag    = bypass ? wrTag    : rdTag;
   assign entTarget = bypass ? WrTarget : rdTarget;
   assign entCtrl   = bypass ? WrCtrl   : rdCtrl;

   assign hitF  = !RST && entValid && (entTag == fetchTag);
   assign ctrlF = hitF ? entCtrl : CTRL_STRONG_NT;

   assign HitF        = hitF;
   assign PredTakenF  = hitF && isTaken(ctrlF);
   assign PredTargetF = hitF ? entTarget : '0;

   // Fetch -> branch-unit stage boundary
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         matchVld_p1 <= 1'b0;
         ctrl_p1     <= CTRL_STRONG_NT;
      end else if (Flush) begin
         matchVld_p1 <= 1'b0;
         ctrl_p1     <= CTRL_STRONG_NT;
      end else if (!Stall) begin
         matchVld_p1 <= hitF;
         ctrl_p1     <= ctrlF;
      end
   end

   assign PcMatchValid = matchVld_p1;
   assign CtrlIn       = ctrl_p1;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, reset sequences and
// randomized traffic compared against an entry-level reference model.
module tb_branch_target_buffer;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [31:0] PcIn = '0;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic        WriteEnable = 1'b0;
   logic [31:0] WrPc = '0;
   logic [31:0] WrTarget = '0;
   logic [1:0]  WrCtrl = '0;
   logic        HitF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        PcMatchValid;
   logic [1:0]  CtrlIn;

   int checks = 0;
   int errors = 0;

   branch_target_buffer #(.PC_W(32), .IDX_W(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .PcIn         (PcIn),
      .Stall        (Stall),
      .Flush        (Flush),
      .WriteEnable  (WriteEnable),
      .WrPc         (WrPc),
      .WrTarget     (WrTarget),
      .WrCtrl       (WrCtrl),
      .HitF         (HitF),
      .PredTakenF   (PredTakenF),
      .PredTargetF  (PredTargetF),
      .PcMatchValid (PcMatchValid),
      .CtrlIn       (CtrlIn)
   );

   always #5 CLK = ~CLK;

   // Reference model: 16 entries addressed by word index modulo 16.
   bit          mV   [16];
   int unsigned mTag [16];
   logic [31:0] mTgt [16];
   logic [1:0]  mCtl [16];
   logic        mMatch = 1'b0;
   logic [1:0]  mCtrlIn = 2'b00;

   typedef struct {
      logic [31:0] pc;
      logic        stall, flush, we;
      logic [31:0] wpc, wtgt;
      logic [1:0]  wctrl;
      logic        eHit, eTaken;
      logic [31:0] eTarget;
      logic        eMatch;
      logic [1:0]  eCtrlIn;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelLookup(output logic hit, output logic [31:0] tgt,
                                       output logic [1:0] ctl);
      int unsigned i;
      bit v;
      int unsigned tg;
      logic [31:0] t;
      logic [1:0] c;
      hit = 1'b0; tgt = '0; ctl = 2'b00;
      if (RST) return;
      i = (PcIn >> 2) % 16;
      v = mV[i]; tg = mTag[i]; t = mTgt[i]; c = mCtl[i];
      // A same-cycle write is visible to the lookup.
      if (WriteEnable && ((WrPc >> 2) % 16) == i) begin
         v = 1'b1; tg = WrPc >> 6; t = WrTarget; c = WrCtrl;
      end
      if (v && tg == (PcIn >> 6)) begin
         hit = 1'b1; tgt = t; ctl = c;
      end
   endfunction

   task automatic drive(input logic rst, input logic [31:0] pc, input logic st,
                        input logic fl, input logic we, input logic [31:0] wpc,
                        input logic [31:0] wtgt, input logic [1:0] wctrl);
      RST = rst; PcIn = pc; Stall = st; Flush = fl;
      WriteEnable = we; WrPc = wpc; WrTarget = wtgt; WrCtrl = wctrl;
      if (rst) begin
         for (int i = 0; i < 16; i++) mV[i] = 1'b0;
         mMatch = 1'b0; mCtrlIn = 2'b00;
      end
      #1;
   endtask

   task automatic checkModel(input string tag);
      logic h; logic [31:0] t; logic [1:0] c;
      modelLookup(h, t, c);
      chk({tag, ".hit"}, 32'(HitF), 32'(h));
      chk({tag, ".taken"}, 32'(PredTakenF), 32'(h & c[1]));
      chk({tag, ".target"}, PredTargetF, t);
      chk({tag, ".match"}, 32'(PcMatchValid), 32'(mMatch));
      chk({tag, ".ctrlIn"}, 32'(CtrlIn), 32'(mCtrlIn));
   endtask

   task automatic tick();
      logic h; logic [31:0] t; logic [1:0] c;
      @(posedge CLK);
      if (!RST) begin
         modelLookup(h, t, c);
         if (Flush) begin
            mMatch = 1'b0; mCtrlIn = 2'b00;
         end else if (!Stall) begin
            mMatch = h; mCtrlIn = c;
         end
         if (WriteEnable) begin
            mV[(WrPc >> 2) % 16]   = 1'b1;
            mTag[(WrPc >> 2) % 16] = WrPc >> 6;
            mTgt[(WrPc >> 2) % 16] = WrTarget;
            mCtl[(WrPc >> 2) % 16] = WrCtrl;
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      //            pc       st  fl  we  wpc      wtgt     wc     hit tk tgt      mv ci
      tbl[0]  = '{32'h40, 0, 0, 0, 32'h0,  32'h0,   2'b00, 0, 0, 32'h0,   0, 2'b00};
      tbl[1]  = '{32'h40, 0, 0, 1, 32'h40, 32'h100, 2'b10, 1, 1, 32'h100, 0, 2'b00};
      tbl[2]  = '{32'h40, 0, 0, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h100, 1, 2'b10};
      tbl[3]  = '{32'h80, 0, 0, 0, 32'h0,  32'h0,   2'b00, 0, 0, 32'h0,   1, 2'b10};
      tbl[4]  = '{32'h80, 0, 0, 1, 32'h80, 32'h200, 2'b11, 1, 1, 32'h200, 0, 2'b00};
      tbl[5]  = '{32'h40, 0, 0, 0, 32'h0,  32'h0,   2'b00, 0, 0, 32'h0,   1, 2'b11};
      tbl[6]  = '{32'h44, 0, 0, 1, 32'h44, 32'h300, 2'b01, 1, 0, 32'h300, 0, 2'b00};
      tbl[7]  = '{32'h44, 0, 0, 0, 32'h0,  32'h0,   2'b00, 1, 0, 32'h300, 1, 2'b01};
      tbl[8]  = '{32'h80, 1, 0, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h200, 1, 2'b01};
      tbl[9]  = '{32'h80, 1, 0, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h200, 1, 2'b01};
      tbl[10] = '{32'h80, 0, 0, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h200, 1, 2'b01};
      tbl[11] = '{32'h80, 1, 1, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h200, 1, 2'b11};
      tbl[12] = '{32'h44, 0, 0, 0, 32'h0,  32'h0,   2'b00, 1, 0, 32'h300, 0, 2'b00};
      tbl[13] = '{32'h40, 0, 0, 1, 32'h40, 32'h104, 2'b10, 1, 1, 32'h104, 1, 2'b01};
      tbl[14] = '{32'h80, 0, 0, 1, 32'h48, 32'h500, 2'b11, 0, 0, 32'h0,   1, 2'b10};
      tbl[15] = '{32'h48, 0, 0, 0, 32'h0,  32'h0,   2'b00, 1, 1, 32'h500, 0, 2'b00};

      // Reset with a lookup of 0x40 pending
      @(negedge CLK);
      drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
      chk("rst.hit", 32'(HitF), 32'd0);
      chk("rst.target", PredTargetF, 32'd0);
      tick();
      tick();

      foreach (tbl[k]) begin
         drive(0, tbl[k].pc, tbl[k].stall, tbl[k].flush, tbl[k].we,
               tbl[k].wpc, tbl[k].wtgt, tbl[k].wctrl);
         chk($sformatf("vec%0d.hit", k), 32'(HitF), 32'(tbl[k].eHit));
         chk($sformatf("vec%0d.taken", k), 32'(PredTakenF), 32'(tbl[k].eTaken));
         chk($sformatf("vec%0d.target", k), PredTargetF, tbl[k].eTarget);
         chk($sformatf("vec%0d.match", k), 32'(PcMatchValid), 32'(tbl[k].eMatch));
         chk($sformatf("vec%0d.ctrlIn", k), 32'(CtrlIn), 32'(tbl[k].eCtrlIn));
         checkModel($sformatf("vec%0d.model", k));
         tick();
      end

      // Three live entries (0x40, 0x44, 0x48); load the register, then reset
      // while stalled and with a coincident write that must be dropped.
      drive(0, 32'h48, 0, 0, 0, 0, 0, 0);
      tick();
      chk("preRst.match", 32'(PcMatchValid), 32'd1);
      drive(0, 32'h48, 1, 0, 0, 0, 0, 0);
      tick();
      drive(1, 32'h48, 1, 0, 1, 32'h4c, 32'h600, 2'b11);
      chk("rstAsync.match", 32'(PcMatchValid), 32'd0);
      chk("rstAsync.ctrlIn", 32'(CtrlIn), 32'd0);
      chk("rstAsync.hit", 32'(HitF), 32'd0);
      tick();
      foreach (tbl[k]) if (k < 3) begin
         drive(0, 32'h40 + 32'(k) * 4, 0, 0, 0, 0, 0, 0);
         chk($sformatf("postRst%0d.hit", k), 32'(HitF), 32'd0);
         chk($sformatf("postRst%0d.target", k), PredTargetF, 32'd0);
         tick();
      end
      drive(0, 32'h4c, 0, 0, 0, 0, 0, 0);
      chk("postRst.droppedWrite", 32'(HitF), 32'd0);
      tick();
      drive(0, 32'h0, 0, 0, 1, 32'h44, 32'h700, 2'b11);
      tick();
      drive(0, 32'h44, 0, 0, 0, 0, 0, 0);
      chk("rewrite.hit", 32'(HitF), 32'd1);
      chk("rewrite.target", PredTargetF, 32'h700);
      tick();
      drive(0, 32'h40, 0, 0, 0, 0, 0, 0);
      chk("rewrite.otherMiss", 32'(HitF), 32'd0);
      tick();

      // Randomized traffic over 4 tags per index to force aliasing
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc, wpc;
         pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         wpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 3) == 0) wpc[5:2] = pc[5:2];
         drive(($urandom_range(0, 299) == 0), pc, ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 3), wpc,
               $urandom, 2'($urandom_range(0, 3)));
         checkModel("rand");
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
